// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data_mem between four cores.
// Define ARB_FIXED_PRIO_EN for fixed priority (core 1 > 2 > 3 > 4) instead of round-robin.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CORES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req1,
  input  logic                    req2,
  input  logic                    req3,
  input  logic                    req4,
  input  logic                    we1,
  input  logic                    we2,
  input  logic                    we3,
  input  logic                    we4,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [ADDR_WIDTH-1:0]   addr2,
  input  logic [ADDR_WIDTH-1:0]   addr3,
  input  logic [ADDR_WIDTH-1:0]   addr4,
  input  logic [2*DATA_WIDTH-1:0] wdata1,
  input  logic [2*DATA_WIDTH-1:0] wdata2,
  input  logic [2*DATA_WIDTH-1:0] wdata3,
  input  logic [2*DATA_WIDTH-1:0] wdata4,
  output logic                    gnt1,
  output logic                    gnt2,
  output logic                    gnt3,
  output logic                    gnt4,
  output logic                    rvalid1,
  output logic                    rvalid2,
  output logic                    rvalid3,
  output logic                    rvalid4,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    busy,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [1:0]              ptr_r, ptr_s;
  logic [1:0]              idx_r, idx_s;
  logic [1:0]              winner_s;
  logic [NUM_CORES-1:0]    req_vec_s;
  logic [NUM_CORES-1:0]    we_vec_s;
  logic [NUM_CORES-1:0]    gnt_r, gnt_s;
  logic [NUM_CORES-1:0]    rvalid_r, rvalid_s;
  logic                    mem_we_r, mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_w_addr_r, mem_w_addr_s;
  logic [ADDR_WIDTH-1:0]   mem_r_addr_r, mem_r_addr_s;
  logic [2*DATA_WIDTH-1:0] mem_w_data_r, mem_w_data_s;
  logic [DATA_WIDTH-1:0]   r_data_r, r_data_s;
  logic [ADDR_WIDTH-1:0]   addr_arr_s  [NUM_CORES];
  logic [2*DATA_WIDTH-1:0] wdata_arr_s [NUM_CORES];

  function automatic logic [NUM_CORES-1:0] one_hot(input logic [1:0] idx);
    logic [NUM_CORES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // First requester at or after ptr, walking upward with wrap.
  function automatic logic [1:0] pick_rr(input logic [NUM_CORES-1:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [1:0] pick_fixed(input logic [NUM_CORES-1:0] req);
    logic [1:0] pick;
    pick = 2'd0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick = 2'(k);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign req_vec_s      = {req4, req3, req2, req1};
  assign we_vec_s       = {we4, we3, we2, we1};
  assign addr_arr_s[0]  = addr1;
  assign addr_arr_s[1]  = addr2;
  assign addr_arr_s[2]  = addr3;
  assign addr_arr_s[3]  = addr4;
  assign wdata_arr_s[0] = wdata1;
  assign wdata_arr_s[1] = wdata2;
  assign wdata_arr_s[2] = wdata3;
  assign wdata_arr_s[3] = wdata4;

  // Winner selection for the current request vector.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner_s = pick_fixed(req_vec_s);
`else
    winner_s = pick_rr(req_vec_s, ptr_r);
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    idx_s        = idx_r;
    gnt_s        = '0;
    rvalid_s     = '0;
    mem_we_s     = 1'b0;
    mem_w_addr_s = mem_w_addr_r;
    mem_r_addr_s = mem_r_addr_r;
    mem_w_data_s = mem_w_data_r;
    r_data_s     = r_data_r;
    case (state_r)
      IDLE: begin
        if (|req_vec_s) begin
          idx_s        = winner_s;
          gnt_s        = one_hot(winner_s);
          mem_we_s     = we_vec_s[winner_s];
          mem_w_addr_s = addr_arr_s[winner_s];
          mem_r_addr_s = addr_arr_s[winner_s];
          mem_w_data_s = wdata_arr_s[winner_s];
          state_s      = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
`ifdef ARB_FIXED_PRIO_EN
        ptr_s = 2'd0;
`else
        ptr_s = idx_r + 2'd1;
`endif
        // mem_we_r still holds the latched transaction type here.
        if (mem_we_r) begin
          state_s = IDLE;
        end else begin
          rvalid_s = one_hot(idx_r);
          state_s  = RDATA;
        end
      end
      RDATA: begin
        r_data_s = mem_r_data;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ptr_r        <= 2'd0;
      idx_r        <= 2'd0;
      gnt_r        <= '0;
      rvalid_r     <= '0;
      mem_we_r     <= 1'b0;
      mem_w_addr_r <= '0;
      mem_r_addr_r <= '0;
      mem_w_data_r <= '0;
      r_data_r     <= '0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      idx_r        <= idx_s;
      gnt_r        <= gnt_s;
      rvalid_r     <= rvalid_s;
      mem_we_r     <= mem_we_s;
      mem_w_addr_r <= mem_w_addr_s;
      mem_r_addr_r <= mem_r_addr_s;
      mem_w_data_r <= mem_w_data_s;
      r_data_r     <= r_data_s;
    end
  end

  assign gnt1       = gnt_r[0];
  assign gnt2       = gnt_r[1];
  assign gnt3       = gnt_r[2];
  assign gnt4       = gnt_r[3];
  assign rvalid1    = rvalid_r[0];
  assign rvalid2    = rvalid_r[1];
  assign rvalid3    = rvalid_r[2];
  assign rvalid4    = rvalid_r[3];
  assign busy       = (state_r != IDLE);
  assign mem_we     = mem_we_r;
  assign mem_w_addr = mem_w_addr_r;
  assign mem_r_addr = mem_r_addr_r;
  assign mem_w_data = mem_w_data_r;
  // Read data is forwarded while in RDATA so it lines up with rvalid.
  assign r_data     = (state_r == RDATA) ? mem_r_data : r_data_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter with a transaction-level model.
// Define ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_v = 4'd0;
  logic [3:0]  we_v = 4'd0;
  logic [7:0]  addr_v [4];
  logic [15:0] wd_v [4];
  logic        gnt1, gnt2, gnt3, gnt4;
  logic        rvalid1, rvalid2, rvalid3, rvalid4;
  logic [7:0]  r_data;
  logic        busy, mem_we;
  logic [7:0]  mem_w_addr, mem_r_addr;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_r_data = 8'd0;

  bit   [7:0]  tb_mem [256];
  bit   [7:0]  ref_mem [256];

  bit   [3:0]  exp_gnt [8];
  bit   [3:0]  exp_rv [8];
  bit          exp_we [8];
  bit          exp_busy [8];
  bit          exp_acc [8];
  bit          exp_rdv [8];
  bit   [7:0]  exp_addr [8];
  bit   [7:0]  exp_rd [8];
  bit   [15:0] exp_wd [8];

  int          cyc = 0;
  int          m_free = 0;
  int          lw = 3;
  logic [7:0]  last_rd = 8'd0;
  logic [3:0]  drop = 4'd0;
  bit          aborted = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit   [7:0]  old20, old21;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req_v[0]), .req2(req_v[1]), .req3(req_v[2]), .req4(req_v[3]),
    .we1(we_v[0]), .we2(we_v[1]), .we3(we_v[2]), .we4(we_v[3]),
    .addr1(addr_v[0]), .addr2(addr_v[1]), .addr3(addr_v[2]), .addr4(addr_v[3]),
    .wdata1(wd_v[0]), .wdata2(wd_v[1]), .wdata3(wd_v[2]), .wdata4(wd_v[3]),
    .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3), .gnt4(gnt4),
    .rvalid1(rvalid1), .rvalid2(rvalid2), .rvalid3(rvalid3), .rvalid4(rvalid4),
    .r_data(r_data), .busy(busy), .mem_we(mem_we),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  // Memory with registered read port; the upper byte address wraps naturally.
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_w_addr]        <= mem_w_data[7:0];
      tb_mem[mem_w_addr + 8'd1] <= mem_w_data[15:8];
    end
    mem_r_data <= tb_mem[mem_r_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [15:0] wd);
    req_v[i]  = 1'b1;
    we_v[i]   = we;
    addr_v[i] = a;
    wd_v[i]   = wd;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      exp_gnt[k] = 4'd0; exp_rv[k] = 4'd0; exp_we[k] = 1'b0; exp_busy[k] = 1'b0;
      exp_acc[k] = 1'b0; exp_rdv[k] = 1'b0;
    end
    last_rd = 8'd0;
    lw      = 3;
    m_free  = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then drive the requesters.
  task automatic cycle(input bit rnd, input bit abort_on_gnt);
    int s, n1, n2, w;
    logic [3:0] g, rv;
    @(negedge clk);
    s  = cyc % 8;
    g  = {gnt4, gnt3, gnt2, gnt1};
    rv = {rvalid4, rvalid3, rvalid2, rvalid1};
    chk_eq("gnt", {28'd0, g}, {28'd0, exp_gnt[s]});
    chk_eq("rvalid", {28'd0, rv}, {28'd0, exp_rv[s]});
    chk_eq("mem_we", {31'd0, mem_we}, {31'd0, exp_we[s]});
    chk_eq("busy", {31'd0, busy}, {31'd0, exp_busy[s]});
    if (exp_acc[s]) begin
      chk_eq("mem_w_addr", {24'd0, mem_w_addr}, {24'd0, exp_addr[s]});
      chk_eq("mem_r_addr", {24'd0, mem_r_addr}, {24'd0, exp_addr[s]});
      chk_eq("mem_w_data", {16'd0, mem_w_data}, {16'd0, exp_wd[s]});
    end
    if (exp_rdv[s]) last_rd = exp_rd[s];
    chk_eq("r_data", {24'd0, r_data}, {24'd0, last_rd});
    if (!rst_n) begin
      chk_eq("rst_w_addr", {24'd0, mem_w_addr}, 32'd0);
      chk_eq("rst_w_data", {16'd0, mem_w_data}, 32'd0);
    end
    exp_gnt[s] = 4'd0; exp_rv[s] = 4'd0; exp_we[s] = 1'b0; exp_busy[s] = 1'b0;
    exp_acc[s] = 1'b0; exp_rdv[s] = 1'b0;
    drop = drop | g;

    if (abort_on_gnt && g != 4'd0) begin
      rst_n = 1'b0;
      #1;
      chk_eq("abort_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'd0);
      chk_eq("abort_we", {31'd0, mem_we}, 32'd0);
      chk_eq("abort_busy", {31'd0, busy}, 32'd0);
      clear_model();
      req_v   = 4'd0;
      drop    = 4'd0;
      aborted = 1'b1;
    end else if (rst_n && cyc >= m_free && req_v != 4'd0) begin
      w = -1;
`ifdef ARB_FIXED_PRIO_EN
      for (int k = 3; k >= 0; k--) if (req_v[k]) w = k;
`else
      for (int k = 4; k >= 1; k--) if (req_v[(lw + k) % 4]) w = (lw + k) % 4;
`endif
      n1 = (cyc + 1) % 8;
      exp_gnt[n1]  = 4'd1 << w;
      exp_busy[n1] = 1'b1;
      exp_we[n1]   = we_v[w];
      exp_acc[n1]  = 1'b1;
      exp_addr[n1] = addr_v[w];
      exp_wd[n1]   = wd_v[w];
      if (we_v[w]) begin
        ref_mem[addr_v[w]]        = wd_v[w][7:0];
        ref_mem[addr_v[w] + 8'd1] = wd_v[w][15:8];
        m_free = cyc + 2;
      end else begin
        n2 = (cyc + 2) % 8;
        exp_rv[n2]   = 4'd1 << w;
        exp_busy[n2] = 1'b1;
        exp_rdv[n2]  = 1'b1;
        exp_rd[n2]   = ref_mem[addr_v[w]];
        m_free = cyc + 3;
      end
      lw = w;
    end

    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (drop[i]) begin
        req_v[i] = 1'b0;
        drop[i]  = 1'b0;
      end else if (rnd && !req_v[i] && $urandom_range(0, 2) == 0) begin
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
                16'($urandom));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = 8'(2 * i);
      wd_v[i]   = 16'd0;
    end
    req_v = 4'hF;
    we_v  = 4'h0;

    // Reset held with every core requesting, then four-way read contention.
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (14) cycle(1'b0, 1'b0);

    // Core 2 writes 0xBEEF to 0x10 and reads both bytes back.
    set_req(1, 1'b1, 8'h10, 16'hBEEF);
    repeat (4) cycle(1'b0, 1'b0);
    chk_eq("mem_0x10", {24'd0, tb_mem[8'h10]}, 32'h0000_00EF);
    chk_eq("mem_0x11", {24'd0, tb_mem[8'h11]}, 32'h0000_00BE);
    set_req(1, 1'b0, 8'h10, 16'd0);
    repeat (5) cycle(1'b0, 1'b0);
    set_req(1, 1'b0, 8'h11, 16'd0);
    repeat (5) cycle(1'b0, 1'b0);

    // Core 4 write at the top address, then cores 1 and 2 read both halves.
    set_req(3, 1'b1, 8'hFF, 16'h1234);
    repeat (4) cycle(1'b0, 1'b0);
    chk_eq("mem_0xff", {24'd0, tb_mem[8'hFF]}, 32'h0000_0034);
    chk_eq("mem_0x00", {24'd0, tb_mem[8'h00]}, 32'h0000_0012);
    set_req(0, 1'b0, 8'hFF, 16'd0);
    set_req(1, 1'b0, 8'h00, 16'd0);
    repeat (8) cycle(1'b0, 1'b0);

    // Reset asserted in the middle of a granted write.
    old20 = ref_mem[8'h20];
    old21 = ref_mem[8'h21];
    set_req(0, 1'b1, 8'h20, 16'hAAAA);
    for (int k = 0; k < 8 && !aborted; k++) cycle(1'b0, 1'b1);
    chk_eq("abort_seen", {31'd0, aborted}, 32'd1);
    chk_eq("abort_mem20", {24'd0, tb_mem[8'h20]}, {24'd0, old20});
    chk_eq("abort_mem21", {24'd0, tb_mem[8'h21]}, {24'd0, old21});
    ref_mem[8'h20] = old20;
    ref_mem[8'h21] = old21;
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 1'b0);

    // Random traffic, then drain whatever is still pending.
    repeat (800) cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);
    chk_eq("drained", {28'd0, req_v}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
